// File: rtl/all_word_same_decomp.sv
// all_word_same_decomp: rebuilds a 256-bit line from a stream of 32-bit beats.
// A line is either a single pattern word repeated eight times (one beat,
// isAllWordSame_i=1 on that beat) or eight raw words (word 0 first, placed
// in the most significant 32 bits). The rebuilt line is held on data_o until
// the downstream side accepts it. No input beat is accepted while a line is
// waiting on the output.
module all_word_same_decomp (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [31:0]  data_i,
  input  logic         isAllWordSame_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [255:0] data_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_cnt;
  logic [2:0]   w_cnt_nxt;
  logic [255:0] r_data;
  logic         w_acc;
  logic [7:0]   w_lsb;

  // ready_o depends on state only, so there is no path from valid_i/ready_i.
  assign ready_o = (r_state == IDLE) || (r_state == COLLECT);
  assign valid_o = (r_state == OUT);
  assign data_o  = r_data;
  assign w_acc   = valid_i & ready_o;

  // Beat k lands at bit (7-k)*32; for a 3-bit counter 7-k is just ~k.
  assign w_lsb = {~r_cnt, 5'b00000};

  // State and beat-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; the flag is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (isAllWordSame_i) begin
            w_state_nxt = OUT;
          end else begin
            w_state_nxt = COLLECT;
            w_cnt_nxt   = 3'd1;
          end
        end
      end
      COLLECT: begin
        if (w_acc) begin
          if (r_cnt == 3'd7) begin
            w_state_nxt = OUT;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      OUT: begin
        if (ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Line register: replicate a pattern word or drop a raw word into its slot.
  // The counter is always 0 in IDLE, so a raw first beat lands in word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_acc) begin
      if ((r_state == IDLE) && isAllWordSame_i) begin
        r_data <= {8{data_i}};
      end else begin
        r_data[w_lsb +: 32] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_all_word_same_decomp.sv
// Testbench for all_word_same_decomp: directed scenarios plus random traffic,
// checked every cycle against a line-level reference model.
module tb_all_word_same_decomp;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [31:0]  data_i;
  logic         isAllWordSame_i;
  logic         valid_o;
  logic         ready_i;
  logic [255:0] data_o;

  all_word_same_decomp u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .data_i          (data_i),
    .isAllWordSame_i (isAllWordSame_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .data_o          (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: words received so far for the current line, and the
  // finished line (if any) waiting for the downstream side.
  logic [31:0]  m_words[8];
  int           m_n;
  bit           m_pending;
  logic [255:0] m_line;
  bit           m_acc;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n       = 0;
    m_pending = 0;
    m_line    = '0;
    m_acc     = 0;
  endtask

  // One rising edge of the model, using the inputs as driven before the edge.
  task automatic model_edge();
    m_acc = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_pending) begin
      if (ready_i) m_pending = 0;
    end else if (valid_i) begin
      m_acc = 1;
      if (m_n == 0 && isAllWordSame_i) begin
        for (int i = 0; i < 8; i++) m_line[255 - 32*i -: 32] = data_i;
        m_pending = 1;
      end else begin
        m_words[m_n] = data_i;
        m_n++;
        if (m_n == 8) begin
          for (int i = 0; i < 8; i++) m_line[255 - 32*i -: 32] = m_words[i];
          m_pending = 1;
          m_n       = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready_o", {255'd0, ready_o}, {255'd0, !m_pending});
    chk("valid_o", {255'd0, valid_o}, {255'd0, m_pending});
    if (m_pending) chk("data_o", data_o, m_line);
  endtask

  // Advance one clock, update the model, then sample the DUT 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Offer one beat until it is accepted (bounded), then leave valid_i as is.
  task automatic send_beat(input logic [31:0] d, input logic flag);
    int n;
    valid_i         = 1'b1;
    data_i          = d;
    isAllWordSame_i = flag;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("beat_timeout", 256'd1, 256'd0);
  endtask

  task automatic idle_in();
    valid_i = 1'b0;
    data_i  = $urandom;
  endtask

  // Send a raw line of words base..base+7; flag=1 on beats 1..7 must be ignored.
  task automatic send_raw(input logic [31:0] base, input int gap_after, input int gap_len);
    for (int k = 0; k < 8; k++) begin
      send_beat(base + k, (k == 0) ? 1'b0 : 1'b1);
      if (k == gap_after) begin
        idle_in();
        for (int g = 0; g < gap_len; g++) cyc();
      end
    end
  endtask

  task automatic drain();
    int n;
    idle_in();
    ready_i = 1'b1;
    n = 0;
    while (m_pending && n < 20) begin
      cyc();
      n++;
    end
    if (m_pending) chk("drain_timeout", 256'd1, 256'd0);
  endtask

  logic [255:0] raw_ref;
  logic [255:0] held;

  initial begin
    rst_n           = 1'b0;
    valid_i         = 1'b0;
    data_i          = '0;
    isAllWordSame_i = 1'b0;
    ready_i         = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) raw_ref[255 - 32*i -: 32] = i;

    // Reset values, then release before the first edge.
    #2;
    chk("rst_ready", {255'd0, ready_o}, 256'd1);
    chk("rst_valid", {255'd0, valid_o}, 256'd0);
    chk("rst_data", data_o, 256'd0);
    rst_n = 1'b1;

    // Pattern line, accepted on the very first edge after reset.
    send_beat(32'hDEADBEEF, 1'b1);
    idle_in();
    chk("pat_valid", {255'd0, valid_o}, 256'd1);
    chk("pat_data", data_o, {8{32'hDEADBEEF}});
    cyc();
    chk("pat_after_valid", {255'd0, valid_o}, 256'd0);
    chk("pat_after_ready", {255'd0, ready_o}, 256'd1);

    // Raw line, no gaps.
    send_raw(32'h0, -1, 0);
    idle_in();
    chk("raw_data", data_o, raw_ref);
    drain();

    // Backpressure on a pattern line.
    ready_i = 1'b0;
    send_beat(32'h12345678, 1'b1);
    idle_in();
    held = data_o;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("bp_hold", data_o, held);
    end
    ready_i = 1'b1;
    cyc();
    chk("bp_release", {255'd0, valid_o}, 256'd0);

    // Gapped raw line: 3 idle cycles after beat 3.
    send_raw(32'h0, 3, 3);
    idle_in();
    chk("gap_data", data_o, raw_ref);
    drain();

    // Reset in the middle of a raw line (after beat 4).
    send_raw(32'hA0, -1, 0);
    drain();
    for (int k = 0; k < 5; k++) send_beat(32'h55 + k, 1'b0);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", {255'd0, ready_o}, 256'd1);
    chk("mid_rst_valid", {255'd0, valid_o}, 256'd0);
    chk("mid_rst_data", data_o, 256'd0);
    cyc();
    rst_n = 1'b1;
    send_beat(32'hCAFEF00D, 1'b1);
    idle_in();
    chk("post_rst_data", data_o, {8{32'hCAFEF00D}});
    drain();

    // Back-to-back: pattern then raw with valid_i held high.
    send_beat(32'hFACE0001, 1'b1);
    send_raw(32'h100, -1, 0);
    idle_in();
    drain();

    // Random traffic, including occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      valid_i         = ($urandom_range(0, 3) != 0);
      data_i          = $urandom;
      isAllWordSame_i = ($urandom_range(0, 2) == 0);
      ready_i         = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_rst_data", data_o, 256'd0);
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/all_word_same_decomp.md
ALL_WORD_SAME_DECOMP -- requirements
Module: all_word_same_decomp

Interface
REQ-001 SHALL have no parameters; line width fixed at 256 bits, word width at 32 bits, 8 words per line.
REQ-002 SHALL provide ports as follows (clock and reset first):
  clk               input   1    single clock; all state updates on rising edge
  rst_n             input   1    reset, asynchronous, active-low
  valid_i           input   1    input beat valid
  ready_o           output  1    block accepts input beat
  data_i            input   32   input beat payload: pattern word or raw word
  isAllWordSame_i   input   1    first-beat flag: 1 = single-word repeated line, 0 = raw line of 8 beats
  valid_o           output  1    reconstructed line valid
  ready_i           input   1    downstream accepts line
  data_o            output  256  reconstructed line
REQ-003 SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 SHALL define input handshake as valid_i & ready_o and output handshake as valid_o & ready_i, both sampled at the rising edge of clk.
REQ-005 SHALL implement FSM states IDLE, COLLECT, OUT.
REQ-006 IDLE: ready_o=1, valid_o=0.
REQ-007 IDLE with handshake and isAllWordSame_i=1: data_o <= {8{data_i}}; next state OUT.
REQ-008 IDLE with handshake and isAllWordSame_i=0: data_i stored in data_o[255:224] (word 0); beat counter <= 1; next state COLLECT.
REQ-009 COLLECT: ready_o=1, valid_o=0; beat k (k=1..7) stored in data_o[255-32k -: 32]; counter increments per handshake only.
REQ-010 COLLECT: isAllWordSame_i SHALL be ignored.
REQ-011 COLLECT: on the handshake with counter=7 (8th beat), next state OUT; counter returns to 0.
REQ-012 COLLECT: cycles without valid_i SHALL hold counter and stored words unchanged (no timeout).
REQ-013 OUT: valid_o=1, ready_o=0; data_o and valid_o stable while ready_i=0.
REQ-014 OUT with ready_i=1: next state IDLE; valid_o deasserts the following cycle.
REQ-015 Latency: valid_o rises exactly one cycle after the accepting edge of the last input beat (1 beat for pattern, 8 beats for raw).
REQ-016 Throughput: minimum 2 cycles per pattern line, 9 cycles per raw line (no input accept in OUT).
REQ-017 ready_o SHALL be a function of state only (no combinational path from ready_i or valid_i).
REQ-018 Byte ordering SHALL match the compressor: word 0 = byte 0..3 = data_o[255:224]; word 7 = data_o[31:0].
REQ-019 data_o contents outside OUT are don't-care to downstream but SHALL NOT contain X after reset.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, counter 0, valid_o=0, ready_o=1, data_o=256'h0, independent of clk.
REQ-021 Reset asserted in COLLECT or OUT SHALL discard the partial or pending line; no line is emitted after deassertion until a new line is fully received.
REQ-022 After rst_n deasserts, the first rising edge SHALL be able to accept a beat.

Verification
REQ-023 Pattern line: beat data_i=32'hDEADBEEF, flag=1, ready_i=1 -> next cycle valid_o=1, data_o={8{32'hDEADBEEF}}; cycle after, valid_o=0, ready_o=1.
REQ-024 Raw line: 8 consecutive beats 32'h00000000..32'h00000007, flag=0 on beat 0 and 1 on beats 1..7 -> data_o=256'h00000000_00000001_..._00000007, valid_o one cycle after beat 7.
REQ-025 Backpressure: pattern 32'h12345678 with ready_i=0 for 5 cycles -> valid_o=1 and data_o unchanged for 5 cycles, ready_o=0 throughout; released on first cycle with ready_i=1.
REQ-026 Gapped input: raw line with valid_i dropped for 3 cycles after beat 3 -> same data_o as gap-free case, valid_o one cycle after beat 7.
REQ-027 Reset mid-line: assert rst_n=0 after beat 4 of raw line -> outputs at reset values immediately; subsequent pattern beat 32'hCAFEF00D yields data_o={8{32'hCAFEF00D}} with no remnant.
REQ-028 Back-to-back: pattern line then raw line with valid_i held high and ready_i=1 -> exactly one idle (ready_o=0) cycle between lines; both lines correct.
